// File: rtl/debounce_filter_if.sv
// Button-side signal bundle for debounce_filter: raw input and sample strobe in,
// debounced level, event pulses, press counter and FSM state out.
interface debounce_filter_if;
    logic       sample_en;
    logic       nbtn;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic       btn_hold;
    logic [7:0] press_cnt;
    logic [1:0] fsm_state;

    modport master (
        output sample_en, nbtn,
        input  btn_level, btn_press, btn_release, btn_hold, press_cnt, fsm_state
    );

    modport slave (
        input  sample_en, nbtn,
        output btn_level, btn_press, btn_release, btn_hold, press_cnt, fsm_state
    );
endinterface

// File: rtl/debounce_filter.sv
// Push-button debouncer: synchronizes the raw active-low button, accepts level
// changes after DEBOUNCE_N stable strobes, and reports press/release/long-press.
module debounce_filter #(
    parameter int                SYNC_STAGES = 2,
    parameter int                CNT_W       = 16,
    parameter logic [CNT_W-1:0]  DEBOUNCE_N  = 16'd20,
    parameter logic [CNT_W-1:0]  HOLD_N      = 16'd1000
) (
    input  logic                 clk,
    input  logic                 nRST,
    debounce_filter_if.slave     bus
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PEND_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        PEND_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = DEBOUNCE_N - 1'b1;
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_N - 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed_s;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [7:0]       press_cnt_q, press_cnt_nxt;
    logic             press_nxt, release_nxt, hold_p_nxt;
    logic             level_q, press_q, release_q, hold_q;

    // pressed_s is the inverted synchronizer output, re-timed once more so the
    // FSM always sees a full-cycle clean level.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            sync_q    <= '1;
            pressed_s <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.nbtn};
            pressed_s <= ~sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state       <= RELEASED;
            cnt         <= '0;
            hold_cnt    <= '0;
            press_cnt_q <= '0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hold_cnt    <= hold_nxt;
            press_cnt_q <= press_cnt_nxt;
            level_q     <= (state_nxt == PRESSED) || (state_nxt == PEND_RELEASE);
            press_q     <= press_nxt;
            release_q   <= release_nxt;
            hold_q      <= hold_p_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hold_nxt      = hold_cnt;
        press_cnt_nxt = press_cnt_q;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        hold_p_nxt    = 1'b0;
        case (state)
            RELEASED: begin
                if (pressed_s) begin
                    state_nxt = PEND_PRESS;
                    cnt_nxt   = '0;
                end
            end
            PEND_PRESS: begin
                // A reverting input beats a coincident final strobe.
                if (!pressed_s) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (bus.sample_en) begin
                    if (cnt == DEB_LAST) begin
                        state_nxt     = PRESSED;
                        cnt_nxt       = '0;
                        hold_nxt      = '0;
                        press_nxt     = 1'b1;
                        press_cnt_nxt = press_cnt_q + 8'd1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_nxt = PEND_RELEASE;
                    cnt_nxt   = '0;
                end else if (bus.sample_en && (hold_cnt != HOLD_N)) begin
                    hold_nxt   = hold_cnt + 1'b1;
                    hold_p_nxt = (hold_cnt == HOLD_LAST);
                end
            end
            PEND_RELEASE: begin
                // Returning to PRESSED keeps hold_cnt, so a saturated count
                // cannot fire btn_hold a second time within one press.
                if (pressed_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (bus.sample_en) begin
                    if (cnt == DEB_LAST) begin
                        state_nxt   = RELEASED;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_hold    = hold_q;
    assign bus.press_cnt   = press_cnt_q;
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_debounce_filter.sv
// Directed and randomized checks of debounce_filter against a cycle-level
// reference model of the accepted-level / pending-candidate behaviour.
module tb_debounce_filter;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic nrst;

    debounce_filter_if bus();

    debounce_filter #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (16),
        .DEBOUNCE_N  (16'(DEB)),
        .HOLD_N      (16'(HOLD))
    ) dut (
        .clk  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_q[$];
    logic       m_level, m_pending;
    int         m_cnt, m_hold;
    logic       m_press, m_release, m_hold_p;
    logic [7:0] m_pc;
    logic [11:0] exp_q[$];

    // event bookkeeping from observed outputs
    int cyc = 0;
    int n_press = 0, n_release = 0, n_hold = 0, n_level_hi = 0;
    int t_press = -1000, t_release = -1000, t_hold = -1000;
    int p0, r0, h0, l0, t0;

    function automatic logic [11:0] out_vec();
        return {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold, bus.press_cnt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs present at the edge.
    task automatic model_edge();
        bit p;
        m_press = 1'b0; m_release = 1'b0; m_hold_p = 1'b0;
        if (!nrst) begin
            m_q = {};
            for (int i = 0; i < SYNC + 1; i++) m_q.push_back(1'b1);
            m_level = 1'b0; m_pending = 1'b0; m_cnt = 0; m_hold = 0; m_pc = 8'd0;
        end else begin
            p = ~m_q.pop_front();
            m_q.push_back(bus.nbtn);
            if (!m_pending) begin
                if (p != m_level) begin
                    m_pending = 1'b1;
                    m_cnt = 0;
                end else if (m_level && bus.sample_en && m_hold < HOLD) begin
                    m_hold++;
                    if (m_hold == HOLD) m_hold_p = 1'b1;
                end
            end else if (p == m_level) begin
                m_pending = 1'b0;
                m_cnt = 0;
            end else if (bus.sample_en) begin
                if (m_cnt == DEB - 1) begin
                    m_pending = 1'b0;
                    m_cnt = 0;
                    m_level = p;
                    if (p) begin
                        m_press = 1'b1;
                        m_pc = m_pc + 8'd1;
                        m_hold = 0;
                    end else begin
                        m_release = 1'b1;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
        exp_q.push_back({m_level, m_press, m_release, m_hold_p, m_pc});
    endtask

    task automatic step();
        logic [11:0] e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
        check("outputs_vs_model", {20'd0, out_vec()}, {20'd0, e});
        check("press_and_release", {31'd0, bus.btn_press & bus.btn_release}, 32'd0);
        check("hold_and_press", {31'd0, bus.btn_hold & bus.btn_press}, 32'd0);
        if (bus.btn_press)   begin n_press++;   t_press = cyc;   end
        if (bus.btn_release) begin n_release++; t_release = cyc; end
        if (bus.btn_hold)    begin n_hold++;    t_hold = cyc;    end
        if (bus.btn_level)   n_level_hi++;
    endtask

    initial begin
        nrst = 1'b0;
        bus.nbtn = 1'b1;
        bus.sample_en = 1'b1;
        step(); step();
        check("reset_outputs", {20'd0, out_vec()}, 32'd0);
        nrst = 1'b1;
        repeat (4) step();

        // bounce: 3 low, 3 high, five times
        p0 = n_press; l0 = n_level_hi;
        for (int r = 0; r < 5; r++) begin
            bus.nbtn = 1'b0; repeat (3) step();
            bus.nbtn = 1'b1; repeat (3) step();
        end
        repeat (6) step();
        check("bounce_no_press", n_press - p0, 32'd0);
        check("bounce_level_low", n_level_hi - l0, 32'd0);
        check("bounce_press_cnt", {24'd0, bus.press_cnt}, 32'd0);

        // clean press, long hold of 30 cycles, then release
        p0 = n_press; h0 = n_hold;
        bus.nbtn = 1'b0; t0 = cyc;
        for (int i = 0; i < 40 && n_press == p0; i++) step();
        check("press_seen", n_press - p0, 32'd1);
        check("press_latency", t_press - t0, 32'd8);
        check("press_level", {31'd0, bus.btn_level}, 32'd1);
        check("press_cnt_one", {24'd0, bus.press_cnt}, 32'd1);
        while (cyc - t0 < 30) step();
        check("hold_once", n_hold - h0, 32'd1);
        check("hold_offset", t_hold - t_press, 32'd8);
        r0 = n_release;
        bus.nbtn = 1'b1; t0 = cyc;
        for (int i = 0; i < 40 && n_release == r0; i++) step();
        check("release_seen", n_release - r0, 32'd1);
        check("release_latency", t_release - t0, 32'd8);
        check("release_level", {31'd0, bus.btn_level}, 32'd0);
        repeat (10) step();

        // sparse strobe: one sample_en every 10th cycle
        p0 = n_press;
        bus.nbtn = 1'b0; t0 = cyc;
        for (int i = 1; i <= 60; i++) begin
            bus.sample_en = (i % 10 == 0);
            step();
        end
        check("sparse_press_seen", n_press - p0, 32'd1);
        check("sparse_press_latency", t_press - t0, 32'd40);
        r0 = n_release;
        bus.nbtn = 1'b1; t0 = cyc;
        for (int i = 1; i <= 60; i++) begin
            bus.sample_en = (i % 10 == 0);
            step();
        end
        check("sparse_release_seen", n_release - r0, 32'd1);
        check("sparse_release_latency", t_release - t0, 32'd40);
        bus.sample_en = 1'b1;
        repeat (5) step();

        // reset in PEND_PRESS, full re-debounce, then reset in PRESSED
        r0 = n_release;
        bus.nbtn = 1'b0;
        repeat (5) step();
        nrst = 1'b0; step();
        check("rst_pend_outputs", {20'd0, out_vec()}, 32'd0);
        nrst = 1'b1; p0 = n_press; t0 = cyc;
        for (int i = 0; i < 40 && n_press == p0; i++) step();
        check("rst_redebounce_latency", t_press - t0, 32'd8);
        repeat (3) step();
        nrst = 1'b0; step();
        check("rst_pressed_outputs", {20'd0, out_vec()}, 32'd0);
        nrst = 1'b1; bus.nbtn = 1'b1;
        repeat (12) step();
        check("rst_no_release", n_release - r0, 32'd0);

        // randomized segments with random strobes and rare resets
        for (int k = 0; k < 3000; ) begin
            int len;
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
            bus.nbtn = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                bus.sample_en = ($urandom_range(0, 3) != 0);
                nrst = ($urandom_range(0, 399) != 0);
                step();
                k++;
            end
        end
        nrst = 1'b1; bus.sample_en = 1'b1; bus.nbtn = 1'b1;
        repeat (12) step();

        // press counter wrap after 256 clean presses from reset
        nrst = 1'b0; step();
        nrst = 1'b1;
        repeat (6) step();
        p0 = n_press;
        for (int n = 0; n < 256; n++) begin
            bus.nbtn = 1'b0; repeat (10) step();
            bus.nbtn = 1'b1; repeat (10) step();
        end
        check("wrap_presses", n_press - p0, 32'd256);
        check("wrap_press_cnt", {24'd0, bus.press_cnt}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the input synchronizer depth (legal values 2..4).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the debounce and hold counters.
REQ-003 The block SHALL have parameter DEBOUNCE_N, default 16'd20, giving the stable samples needed to accept a level change (legal values 1..2^CNT_W-1).
REQ-004 The block SHALL have parameter HOLD_N, default 16'd1000, giving the samples in PRESSED before a long-press pulse (legal values 1..2^CNT_W-1).
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 nRST  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 sample_en  input  1  one-cycle sample strobe from the upstream prescaler; debounce and hold counters advance only when it is high.
REQ-008 nbtn  input  1  raw, asynchronous push-button; 0 = pressed.
REQ-009 btn_level  output  1  debounced level; 1 = pressed.
REQ-010 btn_press  output  1  one-cycle pulse on an accepted press.
REQ-011 btn_release  output  1  one-cycle pulse on an accepted release.
REQ-012 btn_hold  output  1  one-cycle pulse, at most once per press, when the press lasts HOLD_N samples.
REQ-013 press_cnt  output  8  count of accepted presses.

Function
REQ-014 nbtn SHALL pass through a SYNC_STAGES flop chain before any use; pressed_s = inverted synchronizer output.
REQ-015 The FSM SHALL have exactly four states: RELEASED, PEND_PRESS, PRESSED and PEND_RELEASE.
REQ-016 In RELEASED, pressed_s=1 SHALL move the FSM to PEND_PRESS with cnt=0; otherwise the FSM SHALL stay.
REQ-017 In PEND_PRESS, pressed_s=0 SHALL move the FSM to RELEASED with cnt=0, regardless of sample_en.
REQ-018 In PEND_PRESS with pressed_s=1 and sample_en=1: if cnt==DEBOUNCE_N-1 the FSM SHALL go to PRESSED with cnt=0; else cnt SHALL increment.
REQ-019 In PEND_PRESS with pressed_s=1 and sample_en=0, the state and cnt SHALL hold.
REQ-020 PRESSED and PEND_RELEASE SHALL mirror REQ-016..019 with pressed_s inverted; acceptance SHALL lead to RELEASED.
REQ-021 In PRESSED with pressed_s=1 and sample_en=1, hold_cnt SHALL increment, saturating at HOLD_N.
REQ-022 btn_hold SHALL pulse in the cycle after hold_cnt reaches HOLD_N, and never again until the next press is accepted.
REQ-023 hold_cnt SHALL clear on entry to PRESSED, and SHALL hold (not clear) during PEND_RELEASE.
REQ-024 A PEND_RELEASE that returns to PRESSED SHALL NOT re-pulse btn_press and SHALL NOT re-arm btn_hold.
REQ-025 btn_level SHALL be 1 exactly in PRESSED and PEND_RELEASE.
REQ-026 All outputs SHALL be registered; each pulse SHALL be high in the first cycle the FSM is in the new state.
REQ-027 press_cnt SHALL increment by 1 with every btn_press, wrapping 255 -> 0 silently.
REQ-028 Latency SHALL be: nbtn edge -> btn_press = SYNC_STAGES + 1 cycles + DEBOUNCE_N sample_en strobes + 1 cycle.
REQ-029 Equal-priority events SHALL resolve as follows: a bounce (pressed_s reverting) in the same cycle as the final sample_en SHALL abort the acceptance, so the reverting input wins.
REQ-030 btn_press and btn_release SHALL never be high in the same cycle.
REQ-031 btn_hold SHALL never coincide with btn_press.

Reset
REQ-032 With nRST=0 at a rising clk edge, all of the following SHALL be forced: synchronizer flops 1 (released), FSM RELEASED, cnt=0, hold_cnt=0, press_cnt=0, and all outputs 0.
REQ-033 Reset SHALL take effect even mid-pending or mid-hold, without emitting btn_release.
REQ-034 After reset deasserts, the block SHALL need a full debounce to accept a button that is already held down.

Verification
REQ-035 Setup: DEBOUNCE_N=4, HOLD_N=8, sample_en=1 every cycle, SYNC_STAGES=2; drive nbtn 1 -> 0 at cycle 0 -> btn_press at cycle 8, btn_level=1 from cycle 8, press_cnt=1.
REQ-036 Bounce: nbtn low for 3 cycles, then high, repeated 5 times -> no btn_press, btn_level stays 0, press_cnt=0.
REQ-037 Long press: hold nbtn=0 for 30 cycles -> exactly one btn_hold, 8 samples after the btn_press cycle; then release -> btn_release 8 cycles after the nbtn rise.
REQ-038 Sparse strobe: sample_en every 10th cycle, nbtn held low -> btn_press only after 4 strobes are seen while in PEND_PRESS.
REQ-039 Wrap: 256 clean presses -> press_cnt returns to 0, with no glitch on the other outputs.
REQ-040 Reset mid-operation: assert nRST=0 in PEND_PRESS and again in PRESSED -> all outputs 0 on the next edge, and no btn_release pulse.
